// File: rtl/snake_ctrl.sv
// snake_ctrl: snake-game move sequencer owning the body ring buffer and the 8x16 framebuffer
module snake_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int PTR_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir_valid,
  input  logic [1:0]       dir_in,
  input  logic [7:0]       food_pos,
  output logic [127:0]     pixel_reg,
  output logic [7:0]       head_pos,
  output logic [7:0]       tail_pos,
  output logic [PTR_W:0]   length,
  output logic             grow,
  output logic             game_over,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;
  state_t r_state, w_next_state;
  logic [7:0]       r_buf [MAX_LEN];
  logic [PTR_W-1:0] r_hptr, r_tptr;
  logic [PTR_W:0]   r_len;
  logic [127:0]     r_pixel, w_pix;
  logic [7:0]       r_head, r_tail, r_next, w_next_head;
  logic [1:0]       r_dir, r_pend;
  logic             r_eat, r_grow_en, r_hit, r_grow, r_over;
  logic [2:0]       w_row;
  logic [3:0]       w_col;
  logic             w_eat, w_grow_en, w_hit;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next_state;
  always_comb
    w_next_state = r_state == IDLE ? ((step && !r_over) ? CALC : IDLE) :
                   r_state == CALC ? COMMIT : IDLE;
  always_comb
    busy = r_state != IDLE;
  // Rows and columns wrap naturally through their 3- and 4-bit widths
  always_comb begin
    w_row       = r_head[6:4] + (r_pend == 2'd2 ? 3'd1 : r_pend == 2'd0 ? 3'd7 : 3'd0);
    w_col       = r_head[3:0] + (r_pend == 2'd1 ? 4'd1 : r_pend == 2'd3 ? 4'hF : 4'd0);
    w_next_head = {1'b0, w_row, w_col};
    w_eat       = w_next_head == food_pos;
    w_grow_en   = w_eat && !r_len[PTR_W];
    w_hit       = !r_pixel[w_next_head[6:0]] && !(w_next_head == r_tail && !w_grow_en);
  end
  // Head clear is applied last so it wins when the head enters the vacated tail cell
  always_comb begin
    w_pix = r_pixel;
    if (!r_grow_en) w_pix[r_tail[6:0]] = 1'b1;
    w_pix[r_next[6:0]] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
      r_buf[1]  <= 8'h10;
      r_buf[2]  <= 8'h20;
      r_hptr    <= 2;
      r_tptr    <= 0;
      r_len     <= 3;
      r_head    <= 8'h20;
      r_tail    <= 8'h00;
      r_next    <= 8'h00;
      r_pixel   <= {{95{1'b1}}, 1'b0, {15{1'b1}}, 1'b0, {15{1'b1}}, 1'b0};
      r_dir     <= 2'd2;
      r_pend    <= 2'd2;
      r_eat     <= 1'b0;
      r_grow_en <= 1'b0;
      r_hit     <= 1'b0;
      r_grow    <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_grow <= 1'b0;
      if (dir_valid && dir_in != (r_dir ^ 2'd2)) r_pend <= dir_in;
      if (r_state == CALC) begin
        r_dir     <= r_pend;
        r_next    <= w_next_head;
        r_eat     <= w_eat;
        r_grow_en <= w_grow_en;
        r_hit     <= w_hit;
      end
      if (r_state == COMMIT) begin
        r_grow <= r_eat && !r_hit;
        if (r_hit) r_over <= 1'b1;
        else begin
          r_buf[r_hptr + 1'b1] <= r_next;
          r_hptr  <= r_hptr + 1'b1;
          r_head  <= r_next;
          r_pixel <= w_pix;
          if (r_grow_en) r_len <= r_len + 1'b1;
          else begin
            r_tptr <= r_tptr + 1'b1;
            r_tail <= r_buf[r_tptr + 1'b1];
          end
        end
      end
    end
  end
  assign pixel_reg = r_pixel;
  assign head_pos  = r_head;
  assign tail_pos  = r_tail;
  assign length    = r_len;
  assign grow      = r_grow;
  assign game_over = r_over;
endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: directed checks of snake_ctrl moves, steering, growth, collision and full-length behaviour
module tb_snake_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst = 1'b1, step = 1'b0, dir_valid = 1'b0;
  logic [1:0]   dir_in = 2'd0;
  logic [7:0]   food_pos = 8'h7F;
  logic [127:0] pixel_reg;
  logic [7:0]   head_pos, tail_pos;
  logic [5:0]   length;
  logic         grow, game_over, busy;
  logic         step2 = 1'b0, dir_valid2 = 1'b0;
  logic [1:0]   dir_in2 = 2'd0;
  logic [7:0]   food2 = 8'h7F;
  logic [127:0] pixel2;
  logic [7:0]   head2, tail2;
  logic [2:0]   length2;
  logic         grow2, over2, busy2;
  int n_cmp = 0, n_bad = 0;
  logic [127:0] p_rst;

  snake_ctrl dut (.clk(clk), .rst(rst), .step(step), .dir_valid(dir_valid), .dir_in(dir_in),
    .food_pos(food_pos), .pixel_reg(pixel_reg), .head_pos(head_pos), .tail_pos(tail_pos),
    .length(length), .grow(grow), .game_over(game_over), .busy(busy));

  snake_ctrl #(.MAX_LEN(4), .PTR_W(2)) dut4 (.clk(clk), .rst(rst), .step(step2), .dir_valid(dir_valid2),
    .dir_in(dir_in2), .food_pos(food2), .pixel_reg(pixel2), .head_pos(head2), .tail_pos(tail2),
    .length(length2), .grow(grow2), .game_over(over2), .busy(busy2));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; dir_valid = 1'b0; step2 = 1'b0; food_pos = 8'h7F; food2 = 8'h7F;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic move(output logic [2:0] b);
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0; b[0] = busy;
    @(negedge clk); b[1] = busy;
    @(negedge clk); b[2] = busy;
  endtask

  task automatic send_dir(input logic [1:0] d);
    @(negedge clk); dir_valid = 1'b1; dir_in = d;
    @(negedge clk); dir_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (head_pos !== 8'h20) begin n_bad++; $display("FAIL rst_head: got %h want 20", head_pos); end
    n_cmp++; if (tail_pos !== 8'h00) begin n_bad++; $display("FAIL rst_tail: got %h want 00", tail_pos); end
    n_cmp++; if (length !== 6'd3) begin n_bad++; $display("FAIL rst_len: got %0d want 3", length); end
    n_cmp++; if (pixel_reg !== p_rst) begin n_bad++; $display("FAIL rst_pixel: got %h want %h", pixel_reg, p_rst); end
    n_cmp++; if ({busy, grow, game_over} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {busy, grow, game_over}); end
  endtask

  task automatic test_single_step();
    logic [2:0] b;
    logic [127:0] e;
    do_reset();
    move(b);
    e = '1; e[16] = 1'b0; e[32] = 1'b0; e[48] = 1'b0;
    n_cmp++; if (b !== 3'b011) begin n_bad++; $display("FAIL step_busy: got %b want 011", b); end
    n_cmp++; if (head_pos !== 8'h30) begin n_bad++; $display("FAIL step_head: got %h want 30", head_pos); end
    n_cmp++; if (tail_pos !== 8'h10) begin n_bad++; $display("FAIL step_tail: got %h want 10", tail_pos); end
    n_cmp++; if (pixel_reg !== e) begin n_bad++; $display("FAIL step_pixel: got %h want %h", pixel_reg, e); end
    n_cmp++; if (length !== 6'd3) begin n_bad++; $display("FAIL step_len: got %0d want 3", length); end
  endtask

  task automatic test_rst_mid_move();
    do_reset();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (pixel_reg !== p_rst) begin n_bad++; $display("FAIL midrst_pixel: got %h want %h", pixel_reg, p_rst); end
    @(negedge clk);
    n_cmp++; if (head_pos !== 8'h20) begin n_bad++; $display("FAIL midrst_head: got %h want 20", head_pos); end
  endtask

  task automatic test_dir();
    logic [2:0] b;
    do_reset();
    send_dir(2'd0);
    move(b);
    n_cmp++; if ({game_over, head_pos} !== 9'h030) begin n_bad++; $display("FAIL dir_opposite: got %b/%h want 0/30", game_over, head_pos); end
    do_reset();
    send_dir(2'd0);
    send_dir(2'd3);
    move(b);
    n_cmp++; if (head_pos !== 8'h2F) begin n_bad++; $display("FAIL dir_left_head: got %h want 2F", head_pos); end
    n_cmp++; if (tail_pos !== 8'h10) begin n_bad++; $display("FAIL dir_left_tail: got %h want 10", tail_pos); end
    do_reset();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0; dir_valid = 1'b1; dir_in = 2'd1;
    @(negedge clk); dir_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (head_pos !== 8'h30) begin n_bad++; $display("FAIL dir_calc_now: got %h want 30", head_pos); end
    move(b);
    n_cmp++; if (head_pos !== 8'h31) begin n_bad++; $display("FAIL dir_calc_next: got %h want 31", head_pos); end
  endtask

  task automatic test_wrap();
    logic [2:0] b;
    logic [7:0] eh, et;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      move(b);
      eh = 8'(((k + 2) % 8) * 16);
      et = 8'(k * 16);
      n_cmp++; if (head_pos !== eh) begin n_bad++; $display("FAIL wrap_head%0d: got %h want %h", k, head_pos, eh); end
      n_cmp++; if (tail_pos !== et) begin n_bad++; $display("FAIL wrap_tail%0d: got %h want %h", k, tail_pos, et); end
      n_cmp++; if ($countones(~pixel_reg) != 3) begin n_bad++; $display("FAIL wrap_zeros%0d: got %0d want 3", k, $countones(~pixel_reg)); end
    end
  endtask

  task automatic test_grow();
    logic [3:0] g;
    do_reset();
    food_pos = 8'h30;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0; g[3] = grow;
    @(negedge clk); g[2] = grow;
    @(negedge clk); g[1] = grow;
    n_cmp++; if (length !== 6'd4) begin n_bad++; $display("FAIL grow_len: got %0d want 4", length); end
    n_cmp++; if (tail_pos !== 8'h00) begin n_bad++; $display("FAIL grow_tail: got %h want 00", tail_pos); end
    n_cmp++; if (pixel_reg[0] !== 1'b0) begin n_bad++; $display("FAIL grow_bit0: got %b want 0", pixel_reg[0]); end
    @(negedge clk); g[0] = grow;
    n_cmp++; if (g !== 4'b0010) begin n_bad++; $display("FAIL grow_pulse: got %b want 0010", g); end
  endtask

  task automatic test_tail_chase();
    logic [2:0] b;
    do_reset();
    food_pos = 8'h30; move(b); food_pos = 8'h7F;
    send_dir(2'd1); move(b);
    send_dir(2'd0); move(b);
    send_dir(2'd3); move(b);
    n_cmp++; if ({game_over, head_pos} !== 9'h020) begin n_bad++; $display("FAIL chase_head: got %b/%h want 0/20", game_over, head_pos); end
    n_cmp++; if (tail_pos !== 8'h30) begin n_bad++; $display("FAIL chase_tail: got %h want 30", tail_pos); end
    n_cmp++; if (pixel_reg[32] !== 1'b0 || $countones(~pixel_reg) != 4) begin n_bad++; $display("FAIL chase_pixel: got bit32=%b zeros=%0d want 0/4", pixel_reg[32], $countones(~pixel_reg)); end
  endtask

  task automatic test_collision();
    logic [2:0] b;
    logic [127:0] snap;
    logic anyb;
    do_reset();
    food_pos = 8'h30; move(b);
    food_pos = 8'h40; move(b);
    food_pos = 8'h7F;
    n_cmp++; if (length !== 6'd5) begin n_bad++; $display("FAIL coll_len5: got %0d want 5", length); end
    send_dir(2'd1); move(b);
    send_dir(2'd0); move(b);
    snap = pixel_reg;
    send_dir(2'd3); move(b);
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL coll_over: got %b want 1", game_over); end
    n_cmp++; if ({head_pos, tail_pos} !== 16'h3120) begin n_bad++; $display("FAIL coll_pos: got %h/%h want 31/20", head_pos, tail_pos); end
    n_cmp++; if (pixel_reg !== snap || length !== 6'd5) begin n_bad++; $display("FAIL coll_frozen: got %h len %0d want %h len 5", pixel_reg, length, snap); end
    anyb = 1'b0;
    @(negedge clk); step = 1'b1;
    repeat (4) begin @(negedge clk); anyb = anyb | busy; end
    step = 1'b0;
    n_cmp++; if (anyb !== 1'b0) begin n_bad++; $display("FAIL coll_ignore: got busy %b want 0", anyb); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] bb;
    do_reset();
    @(negedge clk); step = 1'b1;
    for (int i = 0; i < 9; i++) begin @(negedge clk); bb[i] = busy; end
    step = 1'b0;
    n_cmp++; if (bb !== 9'b011011011) begin n_bad++; $display("FAIL b2b_busy: got %b want 011011011", bb); end
    n_cmp++; if (head_pos !== 8'h50) begin n_bad++; $display("FAIL b2b_head: got %h want 50", head_pos); end
  endtask

  task automatic test_max_len();
    do_reset();
    food2 = 8'h30;
    @(negedge clk); step2 = 1'b1;
    @(negedge clk); step2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({grow2, length2} !== 4'b1100) begin n_bad++; $display("FAIL max_first: got grow %b len %0d want 1/4", grow2, length2); end
    food2 = 8'h40;
    @(negedge clk); step2 = 1'b1;
    @(negedge clk); step2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (grow2 !== 1'b1) begin n_bad++; $display("FAIL max_grow: got %b want 1", grow2); end
    n_cmp++; if (length2 !== 3'd4) begin n_bad++; $display("FAIL max_len: got %0d want 4", length2); end
    n_cmp++; if ({head2, tail2} !== 16'h4010) begin n_bad++; $display("FAIL max_pos: got %h/%h want 40/10", head2, tail2); end
    n_cmp++; if ($countones(~pixel2) != 4 || over2 !== 1'b0) begin n_bad++; $display("FAIL max_pixel: got zeros %0d over %b want 4/0", $countones(~pixel2), over2); end
  endtask

  initial begin
    p_rst = '1; p_rst[0] = 1'b0; p_rst[16] = 1'b0; p_rst[32] = 1'b0;
    test_reset();
    test_single_step();
    test_rst_mid_move();
    test_dir();
    test_wrap();
    test_grow();
    test_tail_chase();
    test_collision();
    test_back_to_back();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
